sp_spi_arb: RTL

- Arbitrated SPI register-access master for the SuperMario configuration port (chip-side CS/MOSI/MISO plus a generated serial clock).
- Shares the port between two requesters: port 0 (host/PC configuration path) and port 1 (readout sequencer, e.g. on-the-fly register updates between frames).
- Serialises one 16-bit frame per request and returns read data.
- Sits between the requesters and the LVDS pad layer; any pad polarity flipping happens outside this block.

---
 rtl/sp_spi_arb.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sp_spi_arb.sv
// Two-port arbitrated SPI register-access master for the SuperMario configuration port.
// Each accepted request becomes one 16-bit frame {wr, addr, data}, MSB first, with read data returned.
module sp_spi_arb #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic [15:0]       frame_q, frame_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              wr_q, wr_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;

  logic              can_accept, grant0, grant1, accept, cnt_wrap, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Round-robin on ties: the port that did not win last time goes first.
  assign can_accept = nrst && (state_q == IDLE);
  assign grant0     = req0_valid && (!req1_valid || last_grant_q);
  assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
  assign req0_ready = can_accept && grant0;
  assign req1_ready = can_accept && grant1;
  assign accept     = req0_ready || req1_ready;
  assign sel_wr     = grant1 ? req1_wr    : req0_wr;
  assign sel_addr   = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata  = grant1 ? req1_wdata : req0_wdata;
  assign cnt_wrap   = (cnt_q == DivLast);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_wrap ? 8'd0 : cnt_q + 8'd1;
    bit_d        = bit_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    mosi_d       = mosi_q;
    frame_d      = frame_q;
    rx_d         = rx_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    wr_d         = wr_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (accept) begin
          state_d      = SETUP;
          cs_n_d       = 1'b0;
          grant_d      = grant1;
          last_grant_d = grant1;
          wr_d         = sel_wr;
          bit_d        = 4'd15;
          frame_d      = {sel_wr, sel_addr, sel_wr ? sel_wdata : {DATA_W{1'b0}}};
          mosi_d       = sel_wr;
        end
      end
      SETUP: begin
        if (cnt_wrap) state_d = SHIFT;
      end
      SHIFT: begin
        // MISO is captured on the rising transition; MOSI advances on the falling one.
        if (cnt_wrap) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[DATA_W-2:0], spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = HOLD;
            end else begin
              bit_d   = bit_q - 4'd1;
              frame_d = frame_q << 1;
              mosi_d  = frame_q[14];
            end
          end
        end
      end
      HOLD: begin
        if (cnt_wrap) begin
          state_d = DONE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          if (grant_q) rdata1_d = wr_q ? {DATA_W{1'b0}} : rx_q;
          else         rdata0_d = wr_q ? {DATA_W{1'b0}} : rx_q;
        end
      end
      DONE: begin
        cnt_d   = 8'd0;
        state_d = GAP;
      end
      GAP: begin
        if (cnt_wrap) state_d = IDLE;
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      bit_q        <= 4'd15;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      frame_q      <= 16'd0;
      rx_q         <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      wr_q         <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
      frame_q      <= frame_d;
      rx_q         <= rx_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      wr_q         <= wr_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign spi_cs_n   = cs_n_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign rsp0_valid = (state_q == DONE) && !grant_q;
  assign rsp1_valid = (state_q == DONE) && grant_q;
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;

endmodule
